// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and op decode helpers for the byte-serial load/store unit
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Number of bytes an operation touches.
  function automatic logic [2:0] op_size(input mem_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
      default:              op_size = 3'd4;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_t op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of the assembled big-endian load value
module lsu_load_extend
  import lsu_pkg::*;
(
  input  mem_op_t     op,
  input  logic [31:0] value,
  output logic [31:0] rdata
);

  // Stores produce no read data, so they fall through to zero.
  always_comb begin
    rdata = 32'd0;
    case (op)
      OP_LB:   rdata = {{24{value[7]}}, value[7:0]};
      OP_LH:   rdata = {{16{value[15]}}, value[15:0]};
      OP_LW:   rdata = value;
      OP_LBU:  rdata = {24'd0, value[7:0]};
      OP_LHU:  rdata = {16'd0, value[15:0]};
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_byte_lsu.sv
// rtl/mem_byte_lsu.sv - byte-serial big-endian load/store unit with alignment and range checks
module mem_byte_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_t        state_q, state_n;
  mem_op_t           op_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [1:0]        last_q;
  logic [1:0]        k_q;
  logic [31:0]       asm_q;
  logic              err_q;

  mem_op_t     req_op_e;
  logic [2:0]  req_n;
  logic [1:0]  req_last;
  logic [32:0] req_end;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic        accept;
  logic        is_store;
  logic [7:0]  store_byte;
  logic [31:0] ext_rdata;

  assign req_op_e = mem_op_t'(req_op);
  assign req_n    = op_size(req_op_e);
  assign req_last = (req_n == 3'd4) ? 2'd3 : ((req_n == 3'd2) ? 2'd1 : 2'd0);
  // Last byte address in 33 bits so a request near 2^32 cannot wrap into range.
  assign req_end      = {1'b0, req_addr} + {30'd0, req_n} - 33'd1;
  assign out_of_range = req_end >= 33'(DEPTH);
  assign req_err      = misaligned | out_of_range;
  assign accept       = req_valid && (state_q == ST_IDLE);
  assign is_store     = op_is_store(op_q);

  // Alignment rule depends on access size only.
  always_comb begin
    misaligned = 1'b0;
    case (req_n)
      3'd2:    misaligned = req_addr[0];
      3'd4:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Big-endian byte select: byte k of the access is the k-th most significant byte.
  always_comb begin
    store_byte = wdata_q[7:0];
    case (op_q)
      OP_SW: begin
        case (k_q)
          2'd0:    store_byte = wdata_q[31:24];
          2'd1:    store_byte = wdata_q[23:16];
          2'd2:    store_byte = wdata_q[15:8];
          default: store_byte = wdata_q[7:0];
        endcase
      end
      OP_SH:   store_byte = k_q[0] ? wdata_q[7:0] : wdata_q[15:8];
      default: store_byte = wdata_q[7:0];
    endcase
  end

  lsu_load_extend u_extend (
    .op    (op_q),
    .value (asm_q),
    .rdata (ext_rdata)
  );

  // State register; asynchronous reset drops the strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next state and all outputs decoded from registered state only.
  always_comb begin
    state_n    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_n = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_re    = ~is_store;
        mem_we    = is_store;
        mem_addr  = base_q + {{(ADDR_W-2){1'b0}}, k_q};
        mem_wdata = is_store ? store_byte : 8'd0;
        if (k_q == last_q) state_n = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = err_q ? 32'd0 : ext_rdata;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request latches, byte counter and load assembly shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_LB;
      base_q  <= '0;
      wdata_q <= 32'd0;
      last_q  <= 2'd0;
      k_q     <= 2'd0;
      asm_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op_e;
        base_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        last_q  <= req_last;
        k_q     <= 2'd0;
        asm_q   <= 32'd0;
        err_q   <= req_err;
      end else if (state_q == ST_ACCESS) begin
        if (!is_store) asm_q <= {asm_q[23:0], mem_rdata};
        if (k_q != last_q) k_q <= k_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_byte_lsu.sv
// tb/tb_mem_byte_lsu.sv - directed self-checking bench for mem_byte_lsu
module tb_mem_byte_lsu;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3;
  localparam logic [2:0] LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0] mem [DEPTH];

  int          n_checks;
  int          n_errors;
  int          got_cyc;
  int          re_cnt;
  int          we_cnt;
  logic [31:0] got_rdata;
  logic        got_err;
  logic [31:0] log_addr [8];
  logic [7:0]  log_data [8];
  int          resp_seen;

  mem_byte_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide data memory: combinational read, write committed on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE (called #1 after a rising edge) and watch up to 12 cycles.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got_cyc   = -1;
    re_cnt    = 0;
    we_cnt    = 0;
    got_rdata = 32'd0;
    got_err   = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_re) re_cnt++;
      if (mem_we && we_cnt < 8) begin
        log_addr[we_cnt] = 32'(mem_addr);
        log_data[we_cnt] = mem_wdata;
        we_cnt++;
      end
      if (resp_valid) begin
        got_cyc   = c;
        got_rdata = resp_rdata;
        got_err   = resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;

    // Reset values
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Seed bytes 0..3 with AA BB CC DD
    run_req(SW, 32'd0, 32'hAABBCCDD);
    check("seed_resp_cyc", 32'(got_cyc), 32'd5);
    check("seed_mem1", 32'(mem[1]), 32'hBB);

    // Reset in cycle 2 of SW addr 0
    req_op    = SW;
    req_addr  = 32'd0;
    req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rsw_c1_we", 32'(mem_we), 32'd1);
    check("rsw_c1_byte", 32'(mem_wdata), 32'h11);
    @(negedge clk);
    check("rsw_c2_addr", 32'(mem_addr), 32'd1);
    rst = 1'b1;
    #1;
    check("rsw_strobe_drop", {30'd0, mem_re, mem_we}, 32'd0);
    check("rsw_addr_drop", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    check("rsw_no_resp", 32'(resp_seen), 32'd0);
    check("rsw_ready", 32'(req_ready), 32'd1);
    check("rsw_mem0", 32'(mem[0]), 32'h11);
    check("rsw_mem1", 32'(mem[1]), 32'hBB);
    check("rsw_mem2", 32'(mem[2]), 32'hCC);
    check("rsw_mem3", 32'(mem[3]), 32'hDD);
    @(posedge clk);
    #1;

    // SW then LW at addr 8
    run_req(SW, 32'd8, 32'hDEADBEEF);
    check("sw_resp_cyc", 32'(got_cyc), 32'd5);
    check("sw_err", 32'(got_err), 32'd0);
    check("sw_we_cnt", 32'(we_cnt), 32'd4);
    check("sw_re_cnt", 32'(re_cnt), 32'd0);
    check("sw_rdata", got_rdata, 32'd0);
    check("sw_a0", log_addr[0], 32'd8);
    check("sw_a3", log_addr[3], 32'd11);
    check("sw_bytes", {log_data[0], log_data[1], log_data[2], log_data[3]}, 32'hDEADBEEF);
    run_req(LW, 32'd8, 32'd0);
    check("lw_resp_cyc", 32'(got_cyc), 32'd5);
    check("lw_re_cnt", 32'(re_cnt), 32'd4);
    check("lw_rdata", got_rdata, 32'hDEADBEEF);

    // Byte loads of 0x80
    run_req(SB, 32'd3, 32'hFFFFFF80);
    check("sb3_mem", 32'(mem[3]), 32'h80);
    run_req(LB, 32'd3, 32'd0);
    check("lb_rdata", got_rdata, 32'hFFFFFF80);
    check("lb_resp_cyc", 32'(got_cyc), 32'd2);
    check("lb_re_cnt", 32'(re_cnt), 32'd1);
    run_req(LBU, 32'd3, 32'd0);
    check("lbu_rdata", got_rdata, 32'h00000080);
    check("lbu_resp_cyc", 32'(got_cyc), 32'd2);

    // Half store / loads
    run_req(SH, 32'd6, 32'h1234F00D);
    check("sh_resp_cyc", 32'(got_cyc), 32'd3);
    check("sh_mem6", 32'(mem[6]), 32'hF0);
    check("sh_mem7", 32'(mem[7]), 32'h0D);
    run_req(LH, 32'd6, 32'd0);
    check("lh_rdata", got_rdata, 32'hFFFFF00D);
    check("lh_resp_cyc", 32'(got_cyc), 32'd3);
    run_req(LHU, 32'd6, 32'd0);
    check("lhu_rdata", got_rdata, 32'h0000F00D);

    // Errors and range boundary
    run_req(LW, 32'd2, 32'd0);
    check("mis_err", 32'(got_err), 32'd1);
    check("mis_rdata", got_rdata, 32'd0);
    check("mis_resp_cyc", 32'(got_cyc), 32'd1);
    check("mis_strobes", 32'(re_cnt + we_cnt), 32'd0);
    run_req(LH, 32'd5, 32'd0);
    check("mis_h_err", 32'(got_err), 32'd1);
    run_req(LW, 32'd30, 32'd0);
    check("oor_err", 32'(got_err), 32'd1);
    check("oor_strobes", 32'(re_cnt + we_cnt), 32'd0);
    run_req(LB, 32'hFFFFFFFF, 32'd0);
    check("oor_wrap_err", 32'(got_err), 32'd1);
    run_req(SB, 32'd31, 32'h0000005A);
    check("sb31_err", 32'(got_err), 32'd0);
    check("sb31_resp_cyc", 32'(got_cyc), 32'd2);
    check("sb31_mem", 32'(mem[31]), 32'h5A);

    // Busy: req_valid held through LW; LB addr 3 accepted on edge 6
    req_op    = LW;
    req_addr  = 32'd8;
    req_wdata = 32'd0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_op   = LB;
    req_addr = 32'd3;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("busy_ready_c%0d", c), 32'(req_ready), (c <= 5) ? 32'd0 : 32'd1);
      if (c == 5) begin
        check("busy_lw_valid", 32'(resp_valid), 32'd1);
        check("busy_lw_rdata", resp_rdata, 32'hDEADBEEF);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("busy_lb_re", 32'(mem_re), 32'd1);
    check("busy_lb_addr", 32'(mem_addr), 32'd3);
    @(negedge clk);
    check("busy_lb_valid", 32'(resp_valid), 32'd1);
    check("busy_lb_rdata", resp_rdata, 32'hFFFFFF80);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_byte_lsu.md
# mem_byte_lsu

Byte-serial load/store unit between the MEM-stage pipeline register and the byte-wide, big-endian data memory. It accepts one load or store request at a time and checks alignment and range. It then sequences 1, 2 or 4 single-byte memory cycles and returns one response pulse. For loads, the response carries the sign- or zero-extended result; for rejected requests, it carries an error flag. The pipeline stalls on `req_ready` low.

## Interface
- `DEPTH`, 32: data memory size in bytes; must be a power of two, at least 4.
- `ADDR_W`, $clog2(DEPTH): memory-side address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `req_valid`  in  1  request present; held by the requester until accepted.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_op`  in  3  operation (`mem_op_t`): LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low 8, 16 or all 32 bits are used.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or out-of-range request; valid with `resp_valid`.
- `mem_re`  out  1  byte read strobe.
- `mem_we`  out  1  byte write strobe.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_wdata`  out  8  store byte.
- `mem_rdata`  in  8  read byte; combinational in `mem_addr` while `mem_re` is high.

## Operation
- **States:** IDLE, ACCESS, RESP (`lsu_state_t`).
- **IDLE, on accept, size:** n = 1 (byte), 2 (half) or 4 (word).
- **IDLE, on accept, error check:** the request is an error if either condition holds:
  - misaligned: `addr[0]` set for a half; `addr[1:0]` nonzero for a word;
  - out of range: `addr + n - 1 >= DEPTH`, computed in 33 bits with no wrap.
- **IDLE, error path:** go to RESP with `resp_err` set. No memory strobe fires.
- **IDLE, normal path:** latch op, `addr[ADDR_W-1:0]`, wdata and n. Clear byte counter k. Go to ACCESS.
- **ACCESS, per cycle:** `mem_addr = base + k`. Assert `mem_re` for loads or `mem_we` for stores.
- **ACCESS, store byte order (big-endian):**
  - word: byte k = `wdata[31-8k -: 8]`;
  - half: byte k = `wdata[15-8k -: 8]`;
  - byte: `wdata[7:0]`.
- **ACCESS, load capture:** on the same edge, shift the assembled value left by 8 and OR in `mem_rdata`.
- **ACCESS, exit:** when k == n-1, go to RESP; otherwise increment k.
- **RESP:**
  - assert `resp_valid` for one cycle;
  - drive `resp_rdata` = extended assembled value for loads, 0 otherwise;
  - extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend;
  - return to IDLE.
- **Backpressure:** `resp_valid` has none; the consumer must take it.
- **Outputs in IDLE:** all strobes low; `mem_addr`/`mem_wdata` driven 0.
- **Request while busy:** ignored (`req_ready` low). No queueing.

## Timing
- Request accepted on edge 0.
- Byte accesses occupy cycles 1..n. Strobes and address are registered state decoded with no `req_*` combinational path.
- `resp_valid` is high in cycle n+1. Error response comes in cycle 1.
- Throughput: next accept at the earliest in the RESP-to-IDLE following cycle, i.e. one request per n+2 cycles (error: per 2).
- **Reset values:** state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_re` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, counter/latches 0.
- **Reset mid-ACCESS:** strobes drop asynchronously and no response is produced. Bytes already written stay written; no rollback.
- **Memory contract:** data memory commits a write on the same rising edge that ends the ACCESS cycle.

## Structure
- **Package `lsu_pkg`:**
  - `mem_op_t` enum;
  - `lsu_state_t` enum;
  - function `op_size(op)` returning 1/2/4;
  - function `op_is_store(op)`.
- **Sub-module `lsu_load_extend`** (combinational): inputs op and 32-bit assembled value; output extended `resp_rdata`. The FSM, counter, latches and error check stay in the top.

## Test plan
- **SW then LW:** SW addr 8, wdata 0xDEADBEEF. Writes bytes DE, AD, BE, EF at addresses 8..11 in cycles 1-4, with `resp_valid` in cycle 5. LW addr 8 then returns 0xDEADBEEF in cycle 5.
- **Byte loads:** memory[3]=0x80. LB addr 3 gives 0xFFFFFF80; LBU addr 3 gives 0x00000080. Each uses one `mem_re` cycle and responds in cycle 2.
- **Half loads:** SH addr 6, wdata 0x1234F00D writes F0 to addr 6 and 0D to addr 7. LH addr 6 gives 0xFFFFF00D; LHU addr 6 gives 0x0000F00D.
- **Errors:**
  - LW addr 2 gives `resp_err`=1, `resp_rdata`=0 in cycle 1, with no strobe ever asserted.
  - LW addr 30 with DEPTH=32 gives `resp_err`.
  - SB addr 31 succeeds.
- **Busy/backpressure:** `req_valid` held high during a LW accept. `req_ready` stays 0 for cycles 1-5, and the second request is accepted in cycle 6.
- **Reset mid-SW:** `rst` pulsed in cycle 2 of SW addr 0, wdata 0x11223344. Strobes drop immediately and `resp_valid` never fires. Memory[0]=0x11 persists and memory[1..3] are unchanged; `req_ready`=1 after reset.
